motion_frame_accumulator: RTL

//   Downstream stage of the pixel subtractor. Consumes its per-pixel frame_difference/valid_data stream
//   and counts changed pixels across one frame. At end of frame, compares the count to a threshold and

---
 rtl/motion_frame_accumulator.sv | 115 +++++++++++
 1 files changed

// File: rtl/motion_frame_accumulator.sv
// Counts changed pixels over one frame of the subtractor stream and presents a
// per-frame motion verdict on a valid/ready result interface.
module motion_frame_accumulator #(
   parameter int PIXELS_PER_FRAME = 76800,
   parameter int MOTION_THRESHOLD = 1000,
   parameter int CNT_W            = $clog2(PIXELS_PER_FRAME + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             valid_data,
   input  logic             frame_difference,
   input  logic             start_of_frame,
   input  logic             result_ready,
   output logic             result_valid,
   output logic             motion_detected,
   output logic [CNT_W-1:0] diff_count,
   output logic             frame_dropped,
   output logic             sync_error
);

   // state    | meaning
   // WAIT_SOF | idle between frames, ignoring beats until start_of_frame
   // ACCUM    | counting pixels and changed pixels of the current frame
   typedef enum logic {WAIT_SOF, ACCUM} state_t;

   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIXELS_PER_FRAME - 1);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_pix_cnt, w_pix_cnt_nxt;
   logic [CNT_W-1:0] r_acc, w_acc_nxt;
   logic [CNT_W-1:0] w_fd_ext, w_final;
   logic             w_load, w_sync_err, w_motion;

   logic             r_result_valid, r_motion, r_frame_dropped, r_sync_error;
   logic [CNT_W-1:0] r_diff_count;

   assign w_fd_ext = CNT_W'(frame_difference);
   assign w_final  = r_acc + w_fd_ext;
   assign w_motion = (32'(w_final) >= 32'(MOTION_THRESHOLD));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= WAIT_SOF;
         r_pix_cnt <= '0;
         r_acc     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_pix_cnt <= w_pix_cnt_nxt;
         r_acc     <= w_acc_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_pix_cnt_nxt = r_pix_cnt;
      w_acc_nxt     = r_acc;
      w_load        = 1'b0;
      w_sync_err    = 1'b0;
      case (r_state)
         WAIT_SOF: begin
            if (valid_data && start_of_frame) begin
               w_pix_cnt_nxt = CNT_W'(1);
               w_acc_nxt     = w_fd_ext;
               w_state_nxt   = ACCUM;
            end
         end
         ACCUM: begin
            if (valid_data) begin
               // An early start_of_frame wins even on the last-pixel slot
               if (start_of_frame) begin
                  w_pix_cnt_nxt = CNT_W'(1);
                  w_acc_nxt     = w_fd_ext;
                  w_sync_err    = 1'b1;
               end else if (r_pix_cnt == LAST_PIX) begin
                  w_load        = 1'b1;
                  w_pix_cnt_nxt = '0;
                  w_acc_nxt     = '0;
                  w_state_nxt   = WAIT_SOF;
               end else begin
                  w_pix_cnt_nxt = r_pix_cnt + CNT_W'(1);
                  w_acc_nxt     = w_final;
               end
            end
         end
         default: w_state_nxt = WAIT_SOF;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_result_valid  <= 1'b0;
         r_motion        <= 1'b0;
         r_diff_count    <= '0;
         r_frame_dropped <= 1'b0;
         r_sync_error    <= 1'b0;
      end else begin
         r_sync_error    <= w_sync_err;
         r_frame_dropped <= w_load && r_result_valid && !result_ready;
         if (w_load) begin
            r_result_valid <= 1'b1;
            r_motion       <= w_motion;
            r_diff_count   <= w_final;
         end else if (result_ready) begin
            r_result_valid <= 1'b0;
         end
      end
   end

   assign result_valid    = r_result_valid;
   assign motion_detected = r_motion;
   assign diff_count      = r_diff_count;
   assign frame_dropped   = r_frame_dropped;
   assign sync_error      = r_sync_error;

endmodule
